// File: rtl/ex_stage_exmem.sv
// Execute stage and EX/MEM pipeline register of the 5-stage MIPS datapath.
// The stage decodes ALU control, runs the ALU, adds the branch target and
// selects the write register. It also contains a shift-add multiplier that
// holds ID through busy until the product is ready.
module ex_stage_exmem #(
  parameter int          XLEN      = 32,
  parameter logic [5:0]  MUL_FUNCT = 6'h18
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [1:0]      WB,
  input  logic [2:0]      M,
  input  logic            RegDst,
  input  logic [1:0]      ALUop,
  input  logic            ALUsrc,
  input  logic [XLEN-1:0] NextAdress,
  input  logic [XLEN-1:0] OP1,
  input  logic [XLEN-1:0] OP2,
  input  logic [XLEN-1:0] SignExt,
  input  logic [4:0]      RT,
  input  logic [4:0]      RD,
  input  logic            stall_i,
  input  logic            flush,
  output logic            busy,
  output logic            O_valid,
  output logic [1:0]      O_WB,
  output logic [2:0]      O_M,
  output logic [XLEN-1:0] O_BranchAddr,
  output logic            O_Zero,
  output logic [XLEN-1:0] O_ALURes,
  output logic [XLEN-1:0] O_StoreData,
  output logic [4:0]      O_WriteReg
);

  localparam int CNT_W = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [XLEN-1:0]        mcand_p1;
  logic [XLEN-1:0]        mplier_p1;
  logic [XLEN-1:0]        acc_p1;

  logic [5:0]             funct;
  logic [XLEN-1:0]        op_b;
  logic [XLEN-1:0]        alu_res;
  logic [XLEN-1:0]        branch_addr;
  logic [4:0]             write_reg;
  logic                   is_mul;
  logic [XLEN-1:0]        ld_res;
  logic                   ld_valid;
  logic                   load_en;
  logic                   bubble_en;

  // ALU with control decode; unknown R-type functs produce zero.
  function automatic logic [XLEN-1:0] alu_calc(
    input logic [1:0]             op,
    input logic [5:0]             fn,
    input logic signed [XLEN-1:0] a,
    input logic signed [XLEN-1:0] b
  );
    logic [XLEN-1:0] r;
    r = '0;
    case (op)
      2'b00: r = a + b;
      2'b01: r = a - b;
      2'b11: r = {{(XLEN-1){1'b0}}, (a < b)};
      default: begin
        case (fn)
          6'h20:   r = a + b;
          6'h22:   r = a - b;
          6'h24:   r = a & b;
          6'h25:   r = a | b;
          6'h27:   r = ~(a | b);
          6'h2A:   r = {{(XLEN-1){1'b0}}, (a < b)};
          default: r = '0;
        endcase
      end
    endcase
    return r;
  endfunction

  assign funct       = SignExt[5:0];
  assign op_b        = ALUsrc ? SignExt : OP2;
  assign alu_res     = alu_calc(ALUop, funct, $signed(OP1), $signed(op_b));
  assign branch_addr = NextAdress + (SignExt << 2);
  assign write_reg   = RegDst ? RD : RT;
  assign is_mul      = in_valid && (ALUop == 2'b10) && (funct == MUL_FUNCT);

  // The finished product replaces the ALU result when leaving DONE.
  assign ld_res      = (state == DONE) ? acc_p1 : alu_res;
  assign ld_valid    = (state == DONE) ? 1'b1 : in_valid;
  assign load_en     = !flush && !stall_i &&
                       (((state == IDLE) && !is_mul) || (state == DONE));
  assign bubble_en   = !flush && !stall_i && (state == IDLE) && is_mul;

  assign busy        = rst_n && (((state == IDLE) && is_mul) || (state != IDLE));

  // Multiplier control: accept in IDLE, iterate XLEN times, wait in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (is_mul) begin
            state <= MUL;
            cnt   <= '0;
          end
        end
        MUL: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(XLEN - 1)) state <= DONE;
        end
        DONE: begin
          if (!stall_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---- stage p1: shift-add multiplier datapath ----
  // Shift-add step: add the shifted multiplicand for every set multiplier bit.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && is_mul) begin
      mcand_p1  <= OP1;
      mplier_p1 <= op_b;
      acc_p1    <= '0;
    end else if (state == MUL) begin
      acc_p1    <= mplier_p1[0] ? (acc_p1 + mcand_p1) : acc_p1;
      mcand_p1  <= mcand_p1 << 1;
      mplier_p1 <= mplier_p1 >> 1;
    end
  end

  // ---- stage boundary: EX/MEM register ----
  // EX/MEM register: flush clears, stall holds, otherwise load or bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      O_valid      <= 1'b0;
      O_WB         <= '0;
      O_M          <= '0;
      O_BranchAddr <= '0;
      O_Zero       <= 1'b0;
      O_ALURes     <= '0;
      O_StoreData  <= '0;
      O_WriteReg   <= '0;
    end else if (flush || bubble_en) begin
      O_valid      <= 1'b0;
      O_WB         <= '0;
      O_M          <= '0;
      O_BranchAddr <= '0;
      O_Zero       <= 1'b0;
      O_ALURes     <= '0;
      O_StoreData  <= '0;
      O_WriteReg   <= '0;
    end else if (load_en) begin
      O_valid      <= ld_valid;
      O_WB         <= WB;
      O_M          <= M;
      O_BranchAddr <= branch_addr;
      O_Zero       <= (ld_res == '0);
      O_ALURes     <= ld_res;
      O_StoreData  <= OP2;
      O_WriteReg   <= write_reg;
    end
  end

endmodule

// File: tb/tb_ex_stage_exmem.sv
module tb_ex_stage_exmem;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid, RegDst, ALUsrc, stall_i, flush;
  logic [1:0]      WB, ALUop;
  logic [2:0]      M;
  logic [XLEN-1:0] NextAdress, OP1, OP2, SignExt;
  logic [4:0]      RT, RD;
  logic            busy, O_valid, O_Zero;
  logic [1:0]      O_WB;
  logic [2:0]      O_M;
  logic [XLEN-1:0] O_BranchAddr, O_ALURes, O_StoreData;
  logic [4:0]      O_WriteReg;

  // expected EX/MEM contents
  logic            e_valid, e_zero;
  logic [1:0]      e_wb;
  logic [2:0]      e_m;
  logic [XLEN-1:0] e_br, e_res, e_sd;
  logic [4:0]      e_wr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ex_stage_exmem #(.XLEN(XLEN), .MUL_FUNCT(6'h18)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .WB(WB), .M(M),
    .RegDst(RegDst), .ALUop(ALUop), .ALUsrc(ALUsrc), .NextAdress(NextAdress),
    .OP1(OP1), .OP2(OP2), .SignExt(SignExt), .RT(RT), .RD(RD),
    .stall_i(stall_i), .flush(flush), .busy(busy), .O_valid(O_valid),
    .O_WB(O_WB), .O_M(O_M), .O_BranchAddr(O_BranchAddr), .O_Zero(O_Zero),
    .O_ALURes(O_ALURes), .O_StoreData(O_StoreData), .O_WriteReg(O_WriteReg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference ALU straight from the instruction semantics.
  function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [5:0] fn,
                                          input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (op == 2'b00) return a + b;
    if (op == 2'b01) return a - b;
    if (op == 2'b11) return (sa < sb) ? 32'd1 : 32'd0;
    case (fn)
      6'h20: return a + b;
      6'h22: return a - b;
      6'h24: return a & b;
      6'h25: return a | b;
      6'h27: return ~(a | b);
      6'h2A: return (sa < sb) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_load();
    logic [31:0] b;
    b       = ALUsrc ? SignExt : OP2;
    e_valid = in_valid;
    e_wb    = WB;
    e_m     = M;
    e_br    = NextAdress + SignExt * 4;
    e_res   = ref_alu(ALUop, SignExt[5:0], OP1, b);
    e_zero  = (e_res == 0);
    e_sd    = OP2;
    e_wr    = RegDst ? RD : RT;
  endtask

  task automatic model_clear();
    e_valid = 0; e_wb = 0; e_m = 0; e_br = 0;
    e_res = 0; e_zero = 0; e_sd = 0; e_wr = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 32'(O_valid),   32'(e_valid));
    chk({tag, ".wb"},    32'(O_WB),      32'(e_wb));
    chk({tag, ".m"},     32'(O_M),       32'(e_m));
    chk({tag, ".br"},    O_BranchAddr,   e_br);
    chk({tag, ".zero"},  32'(O_Zero),    32'(e_zero));
    chk({tag, ".res"},   O_ALURes,       e_res);
    chk({tag, ".sd"},    O_StoreData,    e_sd);
    chk({tag, ".wr"},    32'(O_WriteReg), 32'(e_wr));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bundle(input logic v, input logic [1:0] wb, input logic [2:0] m,
                            input logic rdst, input logic [1:0] aop, input logic asrc,
                            input logic [31:0] na, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] se, input logic [4:0] rt, input logic [4:0] rd);
    in_valid = v; WB = wb; M = m; RegDst = rdst; ALUop = aop; ALUsrc = asrc;
    NextAdress = na; OP1 = a; OP2 = b; SignExt = se; RT = rt; RD = rd;
  endtask

  // Runs one multiply from acceptance to result; optional stall while in DONE.
  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input int done_stall);
    set_bundle(1, 2'b01, 3'b010, 1, 2'b10, 0, 32'h200, a, b, 32'h18, 5'd3, 5'd12);
    stall_i = 0;
    #1;
    chk({tag, ".busy_pre"}, 32'(busy), 32'd1);
    tick();
    chk({tag, ".bubble"}, 32'(O_valid), 32'd0);
    for (int i = 1; i <= 32; i++) begin
      tick();
      chk({tag, ".busy_run"}, 32'(busy), 32'd1);
      chk({tag, ".valid_run"}, 32'(O_valid), 32'd0);
    end
    stall_i = (done_stall > 0);
    for (int i = 0; i < done_stall; i++) begin
      tick();
      chk({tag, ".busy_done"}, 32'(busy), 32'd1);
      chk({tag, ".valid_done"}, 32'(O_valid), 32'd0);
    end
    stall_i = 0;
    model_load();
    e_res   = a * b;
    e_zero  = (e_res == 0);
    e_valid = 1;
    tick();
    check_all(tag);
    in_valid = 0;
    #1;
    chk({tag, ".busy_post"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    set_bundle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    stall_i = 0;
    flush = 0;
    model_clear();

    // reset state
    tick();
    tick();
    check_all("reset");
    chk("reset.busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1;

    // add: 5 + 7 into rd 9
    set_bundle(1, 2'b10, 3'b000, 1, 2'b10, 0, 32'h40, 32'd5, 32'd7, 32'h20, 5'd2, 5'd9);
    model_load();
    tick();
    check_all("add");
    chk("add.res_const", O_ALURes, 32'd12);
    chk("add.wr_const", 32'(O_WriteReg), 32'd9);

    // beq style compare
    set_bundle(1, 2'b00, 3'b100, 0, 2'b01, 0, 32'h100, 32'h1234, 32'h1234, 32'hFFFFFFFF, 5'd1, 5'd2);
    model_load();
    tick();
    check_all("beq");
    chk("beq.zero_const", 32'(O_Zero), 32'd1);
    chk("beq.br_const", O_BranchAddr, 32'hFC);

    // signed slt
    set_bundle(1, 2'b10, 3'b000, 1, 2'b10, 0, 32'h0, 32'hFFFFFFFF, 32'd1, 32'h2A, 5'd1, 5'd7);
    model_load();
    tick();
    check_all("slt");
    chk("slt.res_const", O_ALURes, 32'd1);

    // lw address
    set_bundle(1, 2'b11, 3'b010, 0, 2'b00, 1, 32'h0, 32'h1000, 32'hABCD, 32'd8, 5'd4, 5'd20);
    model_load();
    tick();
    check_all("lw");
    chk("lw.res_const", O_ALURes, 32'h1008);
    chk("lw.wr_const", 32'(O_WriteReg), 32'd4);

    // randomized single-cycle traffic with stalls and flushes
    for (int n = 0; n < 80; n++) begin
      logic [5:0] fn;
      logic [5:0] tbl [6];
      tbl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
      fn = ($urandom_range(0, 1) == 0) ? tbl[$urandom_range(0, 5)] : 6'($urandom);
      if (fn == 6'h18) fn = 6'h19;
      set_bundle(1'($urandom), 2'($urandom), 3'($urandom), 1'($urandom), 2'($urandom),
                 1'($urandom), $urandom, $urandom, $urandom,
                 {26'($urandom), fn}, 5'($urandom), 5'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        ALUsrc = 0;
        OP2 = OP1;
      end
      stall_i = ($urandom_range(0, 3) == 0);
      flush   = ($urandom_range(0, 7) == 0);
      if (flush) model_clear();
      else if (!stall_i) model_load();
      tick();
      check_all("rnd");
      chk("rnd.busy", 32'(busy), 32'd0);
    end
    stall_i = 0;
    flush = 0;

    // multiply, no stall, then with stall held in DONE
    run_mul("mul", 32'hFFFFFFFD, 32'd7, 0);
    chk("mul.res_const", O_ALURes, 32'hFFFFFFEB);
    ra = $urandom;
    rb = $urandom;
    run_mul("mul_stall", ra, rb, 3);

    // flush during a stalled multiply
    set_bundle(1, 2'b11, 3'b101, 1, 2'b10, 0, 32'h80, 32'd9, 32'd4, 32'h22, 5'd1, 5'd17);
    model_load();
    tick();
    check_all("pre_flush");
    set_bundle(1, 2'b01, 3'b010, 1, 2'b10, 0, 32'h200, 32'd6, 32'd6, 32'h18, 5'd3, 5'd12);
    stall_i = 1;
    tick();
    check_all("flush_hold");
    for (int i = 1; i <= 9; i++) tick();
    chk("flush.busy_pre", 32'(busy), 32'd1);
    flush = 1;
    tick();
    flush = 0;
    stall_i = 0;
    set_bundle(1, 2'b10, 3'b001, 1, 2'b10, 0, 32'h300, 32'd100, 32'd23, 32'h20, 5'd6, 5'd8);
    #1;
    model_clear();
    check_all("flush");
    chk("flush.busy", 32'(busy), 32'd0);
    model_load();
    tick();
    check_all("post_flush");
    chk("post_flush.res_const", O_ALURes, 32'd123);

    // asynchronous reset in the middle of a multiply
    set_bundle(1, 2'b01, 3'b010, 1, 2'b10, 0, 32'h200, 32'd6, 32'd6, 32'h18, 5'd3, 5'd12);
    stall_i = 1;
    tick();
    tick();
    tick();
    chk("rst_mid.busy_pre", 32'(busy), 32'd1);
    chk("rst_mid.valid_pre", 32'(O_valid), 32'd1);
    #2;
    rst_n = 0;
    #1;
    model_clear();
    check_all("rst_mid");
    chk("rst_mid.busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1;
    stall_i = 0;
    set_bundle(1, 2'b10, 3'b000, 0, 2'b10, 0, 32'h0, 32'hF0F0, 32'h0FF0, 32'h24, 5'd11, 5'd13);
    #1;
    chk("rst_mid.busy_after", 32'(busy), 32'd0);
    model_load();
    tick();
    check_all("post_rst");
    chk("post_rst.res_const", O_ALURes, 32'h00F0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
